// File: rtl/ex_flag_unit_pkg.sv
// Shared definitions for the execute-stage flag unit: ALU opcodes,
// branch condition codes, flag bit positions and the flag write-mask decode.
package ex_flag_unit_pkg;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NEQ    = 3'b000,
        BR_EQ     = 3'b001,
        BR_GT     = 3'b010,
        BR_LT     = 3'b011,
        BR_GTE    = 3'b100,
        BR_LTE    = 3'b101,
        BR_OVFL   = 3'b110,
        BR_UNCOND = 3'b111
    } br_cond_e;

    // Which flag bits an ALU opcode is allowed to overwrite
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (alu_op_e'(op))
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ex_flag_unit_if.sv
// EX-stage / ID-branch / EX-MEM signal bundle for the flag unit.
interface ex_flag_unit_if #(parameter int DATA_W = 16);
    logic              ex_valid;
    logic              ex_wr_flags;
    logic [2:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_alu_out;
    logic [2:0]        ex_alu_flags;
    logic              stall;
    logic              flush;
    logic              id_br_valid;
    logic [2:0]        id_br_cond;
    logic [2:0]        flags_q;
    logic              id_br_taken;
    logic              id_br_stall;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_out;
    logic [2:0]        mem_flags;

    // Pipeline control side: drives EX/ID, observes results
    modport master (
        output ex_valid, ex_wr_flags, ex_alu_op, ex_alu_out, ex_alu_flags,
        output stall, flush, id_br_valid, id_br_cond,
        input  flags_q, id_br_taken, id_br_stall, mem_valid, mem_alu_out, mem_flags
    );

    // Flag unit side
    modport slave (
        input  ex_valid, ex_wr_flags, ex_alu_op, ex_alu_out, ex_alu_flags,
        input  stall, flush, id_br_valid, id_br_cond,
        output flags_q, id_br_taken, id_br_stall, mem_valid, mem_alu_out, mem_flags
    );
endinterface

// File: rtl/ex_flag_unit_br_cond_eval.sv
// Combinational branch condition evaluator over a {Z,V,N} flag vector.
module br_cond_eval
    import ex_flag_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic z, v, n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    // Condition table lookup
    always_comb begin
        taken = 1'b0;
        case (br_cond_e'(cond))
            BR_NEQ:    taken = ~z;
            BR_EQ:     taken = z;
            BR_GT:     taken = ~z & ~n;
            BR_LT:     taken = n;
            BR_GTE:    taken = z | (~z & ~n);
            BR_LTE:    taken = n | z;
            BR_OVFL:   taken = v;
            BR_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_flag_unit.sv
// Execute-stage back end: selective flag register, EX/MEM result register
// and ID branch resolution with an optional EX->ID flag bypass.
module ex_flag_unit
    import ex_flag_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_flag_unit_if.slave bus
);
    logic              upd;
    logic [2:0]        mask;
    logic [2:0]        merged_flags;
    logic [2:0]        eff_flags;
    logic              cond_taken;
    logic              br_stall;

    logic [2:0]        flag_q, flag_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] mem_alu_out_q, mem_alu_out_d;
    logic [2:0]        mem_flags_q, mem_flags_d;

    // Decode which flags the EX instruction writes and what they would become
    always_comb begin
        mask         = flag_mask(bus.ex_alu_op);
        upd          = bus.ex_valid & bus.ex_wr_flags & ~bus.flush;
        merged_flags = (flag_q & ~mask) | (bus.ex_alu_flags & mask);
    end

    // Flag register next state: commit only for a live, unstalled writer
    always_comb begin
        flag_d = flag_q;
        if (upd && !bus.stall) begin
            flag_d = merged_flags;
        end
    end

    // EX/MEM next state: flush makes a bubble but keeps data, stall holds all
    always_comb begin
        mem_valid_d   = mem_valid_q;
        mem_alu_out_d = mem_alu_out_q;
        mem_flags_d   = mem_flags_q;
        if (bus.flush) begin
            mem_valid_d = 1'b0;
        end else if (!bus.stall) begin
            mem_valid_d   = bus.ex_valid;
            mem_alu_out_d = bus.ex_alu_out;
            mem_flags_d   = bus.ex_alu_flags;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q        <= 3'b000;
            mem_valid_q   <= 1'b0;
            mem_alu_out_q <= '0;
            mem_flags_q   <= 3'b000;
        end else begin
            flag_q        <= flag_d;
            mem_valid_q   <= mem_valid_d;
            mem_alu_out_q <= mem_alu_out_d;
            mem_flags_q   <= mem_flags_d;
        end
    end

    // Branch flag source: bypass EX when enabled, else stall on a pending writer
    always_comb begin
        eff_flags = flag_q;
        br_stall  = 1'b0;
        if (FWD_EN) begin
            if (upd) begin
                eff_flags = merged_flags;
            end
        end else begin
            br_stall = bus.id_br_valid & upd & (mask != 3'b000);
        end
    end

    br_cond_eval u_br_cond_eval (
        .cond  (bus.id_br_cond),
        .flags (eff_flags),
        .taken (cond_taken)
    );

    assign bus.flags_q     = flag_q;
    assign bus.id_br_stall = br_stall;
    assign bus.id_br_taken = bus.id_br_valid & cond_taken & ~br_stall;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_alu_out = mem_alu_out_q;
    assign bus.mem_flags   = mem_flags_q;
endmodule

// File: tb/tb_ex_flag_unit.sv
// Directed scoreboard bench for ex_flag_unit: a bypassing instance (A) and a
// stalling instance (B) receive identical stimulus; per-cycle expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_ex_flag_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_flag_unit_if #(.DATA_W(16)) bus_a ();
    ex_flag_unit_if #(.DATA_W(16)) bus_b ();

    ex_flag_unit #(.DATA_W(16), .FWD_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ex_flag_unit #(.DATA_W(16), .FWD_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [2:0] sw_cond, sw_flags;
    logic       sw_taken;
    br_cond_eval u_sweep (.cond(sw_cond), .flags(sw_flags), .taken(sw_taken));

    typedef struct {
        int          idx;
        logic [2:0]  fl;
        logic        mv;
        logic [15:0] mo;
        logic [2:0]  mf;
        logic        tka;
        logic        tkb;
        logic        stb;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec    = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [2:0] op, input logic [15:0] out,
                         input logic [2:0] fl, input logic stl, input logic fls, input logic brv,
                         input logic [2:0] cond);
        bus_a.ex_valid = v;   bus_b.ex_valid = v;
        bus_a.ex_wr_flags = wr; bus_b.ex_wr_flags = wr;
        bus_a.ex_alu_op = op; bus_b.ex_alu_op = op;
        bus_a.ex_alu_out = out; bus_b.ex_alu_out = out;
        bus_a.ex_alu_flags = fl; bus_b.ex_alu_flags = fl;
        bus_a.stall = stl;    bus_b.stall = stl;
        bus_a.flush = fls;    bus_b.flush = fls;
        bus_a.id_br_valid = brv; bus_b.id_br_valid = brv;
        bus_a.id_br_cond = cond; bus_b.id_br_cond = cond;
    endtask

    // One cycle of stimulus plus the expected outputs seen before the next edge
    task automatic step(input logic v, input logic wr, input logic [2:0] op, input logic [15:0] out,
                        input logic [2:0] fl, input logic stl, input logic fls, input logic brv,
                        input logic [2:0] cond,
                        input logic [2:0] e_fl, input logic e_mv, input logic [15:0] e_mo,
                        input logic [2:0] e_mf, input logic e_tka, input logic e_tkb, input logic e_stb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, wr, op, out, fl, stl, fls, brv, cond);
        vec++;
        e.idx = vec; e.fl = e_fl; e.mv = e_mv; e.mo = e_mo; e.mf = e_mf;
        e.tka = e_tka; e.tkb = e_tkb; e.stb = e_stb;
        exp_q.push_back(e);
        $display("vec %0d: v=%0b wr=%0b op=%0d out=%h fl=%b stall=%0b flush=%0b br=%0b cond=%0d",
                 vec, v, wr, op, out, fl, stl, fls, brv, cond);
    endtask

    // Monitor: compare every queued expectation against both DUTs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("flags_q_a",     e.idx, 32'(bus_a.flags_q),     32'(e.fl));
            chk("flags_q_b",     e.idx, 32'(bus_b.flags_q),     32'(e.fl));
            chk("mem_valid",     e.idx, 32'(bus_a.mem_valid),   32'(e.mv));
            chk("mem_alu_out",   e.idx, 32'(bus_a.mem_alu_out), 32'(e.mo));
            chk("mem_flags",     e.idx, 32'(bus_a.mem_flags),   32'(e.mf));
            chk("mem_valid_b",   e.idx, 32'(bus_b.mem_valid),   32'(e.mv));
            chk("br_taken_fwd",  e.idx, 32'(bus_a.id_br_taken), 32'(e.tka));
            chk("br_stall_fwd",  e.idx, 32'(bus_a.id_br_stall), 32'd0);
            chk("br_taken_nofwd",e.idx, 32'(bus_b.id_br_taken), 32'(e.tkb));
            chk("br_stall_nofwd",e.idx, 32'(bus_b.id_br_stall), 32'(e.stb));
        end
    end

    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n, t;
        z = f[2]; v = f[1]; n = f[0];
        t = 1'b0;
        case (c)
            3'd0: t = ~z;
            3'd1: t = z;
            3'd2: t = ~z & ~n;
            3'd3: t = n;
            3'd4: t = z | (~z & ~n);
            3'd5: t = n | z;
            3'd6: t = v;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0);
        sw_cond = 3'd0;
        sw_flags = 3'd0;
        #12;
        chk("rst_flags_q",   0, 32'(bus_a.flags_q),     32'd0);
        chk("rst_mem_valid", 0, 32'(bus_a.mem_valid),   32'd0);
        chk("rst_mem_out",   0, 32'(bus_a.mem_alu_out), 32'd0);
        chk("rst_mem_flags", 0, 32'(bus_a.mem_flags),   32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        //   v wr op  out       fl      stl fls brv cond | flags  mv  mo        mf     tka tkb stb
        step(1, 1, 3'd0, 16'h0000, 3'b100, 0, 0, 0, 3'd0,  3'b000, 0, 16'h0000, 3'b000, 0, 0, 0); // ADD
        step(1, 1, 3'd1, 16'h1234, 3'b011, 0, 0, 0, 3'd0,  3'b100, 1, 16'h0000, 3'b100, 0, 0, 0); // SUB
        step(1, 1, 3'd2, 16'h00FF, 3'b100, 0, 0, 0, 3'd0,  3'b011, 1, 16'h1234, 3'b011, 0, 0, 0); // XOR
        step(1, 1, 3'd3, 16'hABCD, 3'b000, 0, 0, 1, 3'd4,  3'b111, 1, 16'h00FF, 3'b100, 1, 1, 0); // RED + GTE
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0,  3'b111, 1, 16'hABCD, 3'b000, 0, 0, 0);
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0,  3'b111, 0, 16'h0000, 3'b000, 0, 0, 0);
        step(1, 1, 3'd0, 16'h0001, 3'b000, 0, 0, 1, 3'd1,  3'b111, 0, 16'h0000, 3'b000, 0, 0, 1); // ADD->000, EQ
        step(1, 1, 3'd0, 16'h0002, 3'b100, 0, 0, 1, 3'd1,  3'b000, 1, 16'h0001, 3'b000, 1, 0, 1); // bypass EQ
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 1, 3'd1,  3'b100, 1, 16'h0002, 3'b100, 1, 1, 0); // stalled resolves
        step(1, 1, 3'd1, 16'h5555, 3'b001, 1, 0, 0, 3'd0,  3'b100, 0, 16'h0000, 3'b000, 0, 0, 0); // SUB stalled
        step(1, 1, 3'd1, 16'h5555, 3'b001, 1, 0, 1, 3'd3,  3'b100, 0, 16'h0000, 3'b000, 1, 0, 1); // LT via bypass
        step(1, 1, 3'd1, 16'h5555, 3'b001, 1, 0, 0, 3'd0,  3'b100, 0, 16'h0000, 3'b000, 0, 0, 0);
        step(1, 1, 3'd1, 16'h5555, 3'b001, 0, 0, 0, 3'd0,  3'b100, 0, 16'h0000, 3'b000, 0, 0, 0); // release
        step(1, 1, 3'd3, 16'h9999, 3'b110, 0, 0, 0, 3'd0,  3'b001, 1, 16'h5555, 3'b001, 0, 0, 0); // RED
        step(1, 1, 3'd0, 16'h7777, 3'b111, 1, 1, 1, 3'd2,  3'b001, 1, 16'h9999, 3'b110, 0, 0, 0); // flush+stall GT
        step(1, 1, 3'd0, 16'h7777, 3'b111, 1, 1, 1, 3'd0,  3'b001, 0, 16'h9999, 3'b110, 1, 1, 0); // flush+stall NEQ
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0,  3'b001, 0, 16'h9999, 3'b110, 0, 0, 0);
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 1, 3'd6,  3'b001, 0, 16'h0000, 3'b000, 0, 0, 0); // OVFL
        step(0, 1, 3'd0, 16'h4444, 3'b100, 0, 0, 1, 3'd1,  3'b001, 0, 16'h0000, 3'b000, 0, 0, 0); // invalid EX
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0,  3'b001, 0, 16'h4444, 3'b100, 0, 0, 0);
        step(1, 1, 3'd4, 16'h0BAD, 3'b110, 0, 0, 0, 3'd0,  3'b001, 0, 16'h0000, 3'b000, 0, 0, 0); // SLL Z only
        step(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 1, 3'd7,  3'b101, 1, 16'h0BAD, 3'b110, 1, 1, 0); // UNCOND

        // Asynchronous reset in the middle of the last cycle, mem_valid high
        @(negedge clk);
        #1;
        chk("pre_rst_mem_valid", 99, 32'(bus_a.mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags_q",   99, 32'(bus_a.flags_q),     32'd0);
        chk("async_rst_mem_valid", 99, 32'(bus_a.mem_valid),   32'd0);
        chk("async_rst_mem_out",   99, 32'(bus_a.mem_alu_out), 32'd0);
        chk("async_rst_mem_flags", 99, 32'(bus_a.mem_flags),   32'd0);
        chk("async_rst_flags_q_b", 99, 32'(bus_b.flags_q),     32'd0);
        $display("async reset applied mid-cycle");
        drive(0, 0, 3'd0, 16'h0000, 3'b000, 0, 0, 0, 3'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Exhaustive condition table sweep
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                sw_cond  = 3'(c);
                sw_flags = 3'(f);
                #1;
                chk("br_cond_eval", c * 8 + f, 32'(sw_taken), 32'(ref_cond(sw_cond, sw_flags)));
            end
        end
        $display("cond sweep done: 64 combinations");

        chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
